dff_pipe: RTL and testbench

- Parametrised successor to the single-bit dff: a WIDTH-bit, DEPTH-stage elastic register pipeline with per-stage valid bits, valid/ready handshakes on both sides, bubble collapsing, synchronous flush and an occupancy counter.
- Instantiated under the project top, in place of the bare dff, wherever a multi-cycle, back-pressurable delay line is needed.

---
 rtl/dff_pipe.sv | 85 ++++++++
 tb/tb_dff_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - WIDTH x DEPTH elastic register pipeline with flush and occupancy count
module dff_pipe #(
    parameter int                WIDTH       = 8,
    parameter int                DEPTH       = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_valid,
    input  logic [WIDTH-1:0]             i_data,
    output logic                         o_ready,
    output logic                         o_valid,
    output logic [WIDTH-1:0]             o_data,
    input  logic                         i_ready,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_depth_check
        $error("dff_pipe: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0]            v_q, v_d, adv;
    logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        in_fire, out_fire;

    // Ready ripples back from the output; an empty stage always advances.
    always_comb begin : p_adv
        logic carry;
        carry = i_ready;
        adv   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            carry  = !v_q[k] | carry;
            adv[k] = carry;
        end
    end

    assign o_ready  = adv[0] & !i_flush;
    assign o_valid  = v_q[DEPTH-1] & !i_flush;
    assign o_data   = d_q[DEPTH-1];
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (i_flush) begin
            v_d = '0;
        end else begin
            if (adv[0]) begin
                v_d[0] = i_valid;
                if (i_valid) begin
                    d_d[0] = i_data;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end
                end
            end
        end
    end

    assign count_d = i_flush ? '0 : (count_q + CW'(in_fire) - CW'(out_fire));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            v_q     <= '0;
            d_q     <= {DEPTH{RESET_VALUE}};
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - scoreboard bench for dff_pipe
module tb_dff_pipe;
    localparam int               WIDTH = 8;
    localparam int               DEPTH = 4;
    localparam logic [WIDTH-1:0] RV    = 8'h5A;
    localparam int               CW    = $clog2(DEPTH + 1);

    logic             i_clk   = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_ready = 1'b0;
    logic             i_flush = 1'b0;
    logic [WIDTH-1:0] i_data  = '0;
    logic             o_ready, o_valid;
    logic [WIDTH-1:0] o_data;
    logic [CW-1:0]    o_count;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    errors   = 0;
    int    cyc      = 0;
    int    last_pop = 0;
    bit    lat_chk  = 1'b0;
    bit    first_pop = 1'b1;

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .i_flush (i_flush),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transfers are decided by the values seen here and take effect on the next rising edge.
    always @(negedge i_clk) begin
        item_t e;
        if (!i_reset) begin
            sb.delete();
        end else begin
            check("count_inv", 32'(o_count), 32'(sb.size()));
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(o_data), 32'(e.data));
                    if (lat_chk) begin
                        check("latency", 32'(cyc - e.cyc), 32'(DEPTH));
                        if (!first_pop) check("gap", 32'(cyc - last_pop), 32'd1);
                        last_pop  = cyc;
                        first_pop = 1'b0;
                    end
                end
            end
            if (i_valid && o_ready) sb.push_back('{i_data, cyc});
            if (i_flush) begin
                check("flush_ready", 32'(o_ready), 32'd0);
                check("flush_valid", 32'(o_valid), 32'd0);
                sb.delete();
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        int n = 0;
        i_valid = 1'b1;
        i_data  = w;
        @(negedge i_clk);
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        i_ready = 1'b1;
        while ((o_count != 0 || o_valid) && n < 100) begin
            step(1);
            n++;
        end
        check("drain_done", 32'(o_count), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_data"},  32'(o_data),  32'(RV));
        check({tag, "_count"}, 32'(o_count), 32'd0);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        #1 i_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = 1'($urandom_range(0, 1));
            i_data  = 8'($urandom);
            @(negedge i_clk);
            check_reset_outputs("rst");
        end
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;

        // Streaming with i_ready held high: fixed latency, no gaps.
        lat_chk   = 1'b1;
        first_pop = 1'b1;
        for (int w = 1; w <= 16; w++) send(8'(w));
        drain();
        lat_chk = 1'b0;

        // Backpressure until full, then release.
        i_ready = 1'b0;
        for (int w = 0; w < 4; w++) send(8'hA0 + 8'(w));
        i_valid = 1'b1;
        i_data  = 8'hA4;
        repeat (3) begin
            @(negedge i_clk);
            check("full_ready", 32'(o_ready), 32'd0);
            check("full_count", 32'(o_count), 32'(DEPTH));
            check("full_hold",  32'(o_data),  32'hA0);
            check("full_valid", 32'(o_valid), 32'd1);
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        send(8'hA4);
        send(8'hA5);
        drain();

        // Bubble collapse behind a stalled output.
        i_ready = 1'b0;
        send(8'h11);
        step(2);
        send(8'h22);
        step(3);
        @(negedge i_clk);
        check("bub_count", 32'(o_count), 32'd2);
        check("bub_head",  32'(o_data),  32'h11);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("bub_first_v", 32'(o_valid), 32'd1);
        check("bub_first",   32'(o_data),  32'h11);
        @(negedge i_clk);
        check("bub_second_v", 32'(o_valid), 32'd1);
        check("bub_second",   32'(o_data),  32'h22);
        drain();

        // Flush with a simultaneous input word.
        i_ready = 1'b0;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h55;
        @(negedge i_clk);
        check("fl_ready", 32'(o_ready), 32'd0);
        check("fl_valid", 32'(o_valid), 32'd0);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("fl_count_after", 32'(o_count), 32'd0);
        check("fl_valid_after", 32'(o_valid), 32'd0);
        check("fl_ready_after", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        send(8'h66);
        drain();

        // Asynchronous reset between edges while full.
        i_ready = 1'b0;
        for (int w = 0; w < 4; w++) send(8'hC0 + 8'(w));
        check("ar_pre_valid", 32'(o_valid), 32'd1);
        #2 i_reset = 1'b0;
        #1 check_reset_outputs("ar");
        step(2);
        i_reset = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("ar_rel");
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        send(8'h77);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
